// File: rtl/ser_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine among NREQ byte streams, holding the grant per line.
// Optional macro SER_TX_ARB_TAG_EN prefixes each grant with "<id>:" tag bytes.
module ser_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);
    localparam int GW = $clog2(NREQ);
    localparam int IW = $clog2(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM
`ifdef SER_TX_ARB_TAG_EN
        , ST_TAG0,
        ST_TAG1
`endif
    } state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [GW-1:0]   ptr_reg, ptr_next;
    logic [7:0]      byte_cnt_reg, byte_cnt_next;
    logic [IW-1:0]   idle_cnt_reg, idle_cnt_next;
    logic            release_now;
    logic [7:0]      req_byte [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_byte
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // First valid requester after p, scanning p+1, p+2, ... with wrap.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [GW-1:0] p);
        logic [GW-1:0] sel;
        int            cand;
        sel = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(p) + k) % NREQ;
            if (v[cand[GW-1:0]]) sel = cand[GW-1:0];
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            ptr_reg      <= GW'(NREQ - 1);
            byte_cnt_reg <= '0;
            idle_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            ptr_reg      <= ptr_next;
            byte_cnt_reg <= byte_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        ptr_next      = ptr_reg;
        byte_cnt_next = byte_cnt_reg;
        idle_cnt_next = idle_cnt_reg;
        release_now   = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = '0;
        req_ready     = '0;
        busy          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_next = rr_pick(req_valid, ptr_reg);
`ifdef SER_TX_ARB_TAG_EN
                    state_next = ST_TAG0;
`else
                    state_next = ST_STREAM;
`endif
                end
            end
`ifdef SER_TX_ARB_TAG_EN
            ST_TAG0: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'h30 + 8'(grant_reg);
                if (tx_ready) state_next = ST_TAG1;
            end
            ST_TAG1: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'h3A;
                if (tx_ready) state_next = ST_STREAM;
            end
`endif
            ST_STREAM: begin
                busy                 = 1'b1;
                tx_valid             = req_valid[grant_reg];
                tx_data              = req_byte[grant_reg];
                req_ready[grant_reg] = tx_ready;
                if (req_valid[grant_reg] && tx_ready) begin
                    byte_cnt_next = byte_cnt_reg + 8'd1;
                    idle_cnt_next = '0;
                    if (req_byte[grant_reg] == 8'h0A || byte_cnt_reg == 8'(MAX_BURST - 1))
                        release_now = 1'b1;
                end else if (!req_valid[grant_reg]) begin
                    if (idle_cnt_reg == IW'(IDLE_TIMEOUT - 1))
                        release_now = 1'b1;
                    else
                        idle_cnt_next = idle_cnt_reg + IW'(1);
                end
                if (release_now) begin
                    state_next    = ST_IDLE;
                    ptr_next      = grant_reg;
                    byte_cnt_next = '0;
                    idle_cnt_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Reset drops the grant immediately so no handshake completes in that cycle.
        if (reset) begin
            tx_valid  = 1'b0;
            tx_data   = '0;
            req_ready = '0;
            busy      = 1'b0;
        end
    end

    assign grant_id = grant_reg;
endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Randomized and directed bench for ser_tx_arbiter against a transaction-level reference model.
module tb_ser_tx_arbiter;
    localparam int NREQ = 4, MAX_BURST = 4, IDLE_TIMEOUT = 8, GW = 2;
`ifdef SER_TX_ARB_TAG_EN
    localparam int NTAG = 2;
`else
    localparam int NTAG = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready = 1'b0;
    logic [GW-1:0]     grant_id;
    logic              busy;

    always #5 clk = ~clk;

    ser_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
    );

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester byte sources
    logic [7:0] qbuf [NREQ][64];
    int         qh [NREQ];
    int         qt [NREQ];
    bit         hold [NREQ];

    // Reference model: who owns the line, tags still owed, bytes sent, quiet cycles
    int m_owner, m_tags, m_grant, m_ptr, m_sent, m_quiet;

    logic [7:0] obs_bytes[$];
    int         obs_cyc[$];
    int         obs_grants[$];
    logic [7:0] exp_bytes[$];
    int         cyc = 0, fall_cyc = -1;
    bit         busy_prev = 1'b0, verbose = 1'b0;

    task automatic model_reset();
        m_owner = -1; m_tags = 0; m_grant = 0; m_ptr = NREQ - 1; m_sent = 0; m_quiet = 0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] e_rdy;
        int o;
        chk("grant_id", grant_id, m_grant);
        if (reset) begin
            chk("rst_txv", tx_valid, 0);
            chk("rst_rdy", req_ready, 0);
            chk("rst_busy", busy, 0);
            model_reset();
        end else if (m_owner < 0) begin
            chk("idle_txv", tx_valid, 0);
            chk("idle_rdy", req_ready, 0);
            chk("idle_busy", busy, 0);
            for (int k = 1; k <= NREQ; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_grant = m_owner; m_tags = NTAG; m_sent = 0; m_quiet = 0;
                end
            end
        end else if (m_tags > 0) begin
            chk("tag_txv", tx_valid, 1);
            chk("tag_txd", tx_data, (m_tags == NTAG) ? 32'h30 + m_owner : 32'h3A);
            chk("tag_rdy", req_ready, 0);
            chk("tag_busy", busy, 1);
            if (tx_ready) m_tags--;
        end else begin
            o = m_owner;
            e_rdy = '0;
            e_rdy[o] = tx_ready;
            chk("str_txv", tx_valid, req_valid[o]);
            if (req_valid[o]) chk("str_txd", tx_data, req_data[8*o +: 8]);
            chk("str_rdy", req_ready, e_rdy);
            chk("str_busy", busy, 1);
            if (req_valid[o] && tx_ready) begin
                m_sent++;
                m_quiet = 0;
                if (req_data[8*o +: 8] == 8'h0A || m_sent == MAX_BURST) begin
                    m_ptr = o; m_owner = -1;
                end
            end else if (!req_valid[o]) begin
                m_quiet++;
                if (m_quiet == IDLE_TIMEOUT) begin
                    m_ptr = o; m_owner = -1;
                end
            end
        end
    endtask

    // tr_mode: 0 = tx_ready always 1, 1 = toggling, 2 = random
    task automatic cycle(input bit rst_in, input int pv, input int tr_mode);
        @(posedge clk);
        #1;
        reset = rst_in;
        case (tr_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = (cyc % 2 == 0);
            default: tx_ready = ($urandom_range(0, 9) < 7);
        endcase
        for (int i = 0; i < NREQ; i++) begin
            if (!hold[i] && qh[i] != qt[i] && $urandom_range(0, 99) < pv) hold[i] = 1'b1;
            req_valid[i] = hold[i];
            req_data[8*i +: 8] = hold[i] ? qbuf[i][qh[i]] : 8'h00;
        end
        @(negedge clk);
        model_step();
        if (!reset && tx_valid && tx_ready) begin
            obs_bytes.push_back(tx_data);
            obs_cyc.push_back(cyc);
            if (verbose) $display("tx cyc=%0d grant=%0d data=%02h", cyc, grant_id, tx_data);
        end
        if (busy && !busy_prev) obs_grants.push_back(int'(grant_id));
        if (!busy && busy_prev) fall_cyc = cyc;
        busy_prev = busy;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                qh[i]++;
                hold[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic push(input int r, input logic [7:0] b);
        qbuf[r][qt[r]] = b;
        qt[r]++;
    endtask

    task automatic clear_logs();
        obs_bytes.delete(); obs_cyc.delete(); obs_grants.delete(); exp_bytes.delete();
        fall_cyc = -1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin
            qh[i] = 0; qt[i] = 0; hold[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 0);
        clear_logs();
    endtask

    task automatic exp_seg(input int g);
        if (NTAG > 0) begin
            exp_bytes.push_back(8'(8'h30 + g));
            exp_bytes.push_back(8'h3A);
        end
    endtask

    task automatic chk_bytes(input string name);
        chk({name, "_len"}, obs_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
            chk($sformatf("%s_b%0d", name, i), obs_bytes[i], exp_bytes[i]);
        exp_bytes.delete();
    endtask

    task automatic run_until_quiet(input string name, input int maxc, input int tr_mode);
        int n;
        bit done, empty;
        n = 0; done = 1'b0;
        while (n < maxc && !done) begin
            cycle(1'b0, 100, tr_mode);
            n++;
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (qh[i] != qt[i] || hold[i]) empty = 1'b0;
            if (empty && !busy) done = 1'b1;
        end
        chk({name, "_done"}, done, 1);
    endtask

    initial begin
        int exp_g[6];
        logic [7:0] filt[$];
        int li;
        model_reset();
        verbose = 1'b1;

        // Reset then idle
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b0, 0, 0);
        chk("idle_bytes", obs_bytes.size(), 0);
        chk("idle_grants", obs_grants.size(), 0);

        // Line lock: "AB\n" from req0 completes before req1's "X"
        do_reset();
        push(0, 8'h41); push(0, 8'h42); push(0, 8'h0A); push(1, 8'h58);
        run_until_quiet("lock", 100, 0);
        exp_seg(0); exp_bytes.push_back(8'h41); exp_bytes.push_back(8'h42); exp_bytes.push_back(8'h0A);
        exp_seg(1); exp_bytes.push_back(8'h58);
        chk_bytes("lock");
        li = -1;
        for (int i = 0; i < obs_bytes.size(); i++) if (li < 0 && obs_bytes[i] == 8'h0A) li = i;
        if (li >= 0 && li + 1 < obs_cyc.size()) chk("lock_gap", obs_cyc[li+1] - obs_cyc[li], 2);
        else chk("lock_gap_found", li, 0);

        // Round-robin with newline-only lines
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            push(r, 8'h0A); push(r, 8'h0A);
        end
        run_until_quiet("rr", 200, 0);
        exp_g = '{0, 1, 2, 3, 0, 1};
        chk("rr_ngrants", obs_grants.size() >= 6, 1);
        for (int i = 0; i < 6 && i < obs_grants.size(); i++) chk($sformatf("rr_g%0d", i), obs_grants[i], exp_g[i]);

        // Burst limit hands the line to req3, then req2 resumes
        do_reset();
        for (int i = 0; i < 10; i++) push(2, 8'(8'h61 + i));
        push(3, 8'h0A);
        run_until_quiet("burst", 300, 0);
        exp_seg(2); for (int i = 0; i < 4; i++) exp_bytes.push_back(8'(8'h61 + i));
        exp_seg(3); exp_bytes.push_back(8'h0A);
        exp_seg(2); for (int i = 4; i < 8; i++) exp_bytes.push_back(8'(8'h61 + i));
        exp_seg(2); exp_bytes.push_back(8'h69); exp_bytes.push_back(8'h6A);
        chk_bytes("burst");
        chk("burst_ngrants", obs_grants.size(), 4);
        if (obs_grants.size() >= 2) chk("burst_g1", obs_grants[1], 3);

        // Idle timeout under toggling backpressure
        do_reset();
        push(1, 8'h55);
        run_until_quiet("tmo", 200, 1);
        exp_seg(1); exp_bytes.push_back(8'h55);
        chk_bytes("tmo");
        if (obs_cyc.size() > 0) chk("tmo_release", fall_cyc - obs_cyc[obs_cyc.size()-1], IDLE_TIMEOUT + 1);

        // Tag prefix (or plain stream without the feature)
        do_reset();
        push(2, 8'h68); push(2, 8'h69); push(2, 8'h0A);
        run_until_quiet("tag", 100, 0);
        exp_seg(2); exp_bytes.push_back(8'h68); exp_bytes.push_back(8'h69); exp_bytes.push_back(8'h0A);
        chk_bytes("tag");

        // Reset mid-stream: no byte lost or duplicated
        do_reset();
        for (int i = 0; i < 10; i++) push(0, 8'(8'h41 + i));
        for (int i = 0; i < 4; i++) cycle(1'b0, 100, 0);
        cycle(1'b1, 100, 0);
        run_until_quiet("mrst", 300, 0);
        filt.delete();
        foreach (obs_bytes[i]) if (obs_bytes[i] >= 8'h41 && obs_bytes[i] <= 8'h4A) filt.push_back(obs_bytes[i]);
        obs_bytes = filt;
        for (int i = 0; i < 10; i++) exp_bytes.push_back(8'(8'h41 + i));
        chk_bytes("mrst");

        // Random traffic against the model
        verbose = 1'b0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (qh[i] == qt[i] && !hold[i] && $urandom_range(0, 15) == 0) begin
                    int n;
                    qh[i] = 0; qt[i] = 0;
                    n = $urandom_range(1, 6);
                    for (int j = 0; j < n; j++)
                        push(i, (j == n - 1 && $urandom_range(0, 1) == 1) ? 8'h0A : 8'($urandom_range(0, 255)));
                end
            end
            cycle($urandom_range(0, 399) == 0, 60, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ser_tx_arbiter.md
Name: ser_tx_arbiter

Overview:
Shares the single SoC serial transmitter among NREQ byte-stream requesters, e.g. CPU console, debug monitor and flash-loader status.
- Round-robin grant with line locking: a grant is held until end-of-line, a burst limit, or an idle timeout, so text lines from different sources never interleave on ser_tx.
- Sits between the requesters and the UART transmit engine. Downstream accepts one byte per valid/ready handshake.

Parameters:
NREQ, 4, number of requesters (2..8; 2..10 when SER_TX_ARB_TAG_EN is defined)
MAX_BURST, 64, maximum bytes per grant before forced release (1..255)
IDLE_TIMEOUT, 256, cycles the granted requester may hold the grant with req_valid low before release (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester byte valid
req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  out  NREQ  per-requester accept; a byte transfers when valid&ready
tx_valid  out  1  byte valid to the UART transmit engine
tx_data  out  8  byte to the UART transmit engine
tx_ready  in  1  UART transmit engine can accept a byte (idle)
grant_id  out  $clog2(NREQ)  index of the current or last granted requester
busy  out  1  high while any requester holds the grant

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; all state updates on posedge clk.
- Reset values: state IDLE; tx_valid=0; tx_data=0; req_ready=0; busy=0; grant_id=0; round-robin pointer=NREQ-1, so requester 0 has first priority; byte count=0; idle counter=0.
- Reset asserted mid-operation: grant dropped in the same cycle. A byte handshaking in that cycle is not transferred; no partial tag is emitted.
- State IDLE (tx_valid=0, req_ready=0, busy=0):
  - If any req_valid is high, pick the first high bit scanning pointer+1, pointer+2, … with modulo-NREQ wrap.
  - Register the pick into grant_id; go to STREAM (or TAG0 when the tag feature is enabled).
  - Arbitration costs exactly one bubble cycle per grant.
- State STREAM (busy=1), with g=grant_id:
  - Combinational pass-through: tx_valid=req_valid[g]; tx_data=req_data[g]; req_ready[g]=tx_ready. All other req_ready bits are 0.
  - On each transfer (req_valid[g]&tx_ready): byte count increments; idle counter clears.
  - Cycle with req_valid[g]=0: idle counter increments.
- Release from STREAM to IDLE, taking effect on the next cycle. Any one of:
  - the transferred byte is 8'h0A;
  - the transfer makes byte count equal MAX_BURST;
  - the idle counter reaches IDLE_TIMEOUT-1 while req_valid[g]=0.
- On release: pointer<=g; byte count and idle counter clear; grant_id keeps its value.
- Simultaneous conditions (0x0A as the MAX_BURST-th byte): single release, counted once.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. A requester waits at most (NREQ-1) bursts.
- Counter widths: byte count is 8 bits; idle counter is $clog2(IDLE_TIMEOUT) bits. Neither wraps, because both clear on release.
- Protocol rules:
  - The arbiter never drops tx_valid while tx_ready=0 and a byte is presented; that is the requester's responsibility, and the arbiter does not re-register data.
  - tx_valid is never high in IDLE.

Optional Feature:
Macro SER_TX_ARB_TAG_EN.
- Defined:
  - After each grant, states TAG0 then TAG1 precede STREAM.
  - TAG0 drives tx_valid=1 and tx_data=8'h30+grant_id (ASCII digit). TAG1 drives tx_valid=1 and tx_data=8'h3A (':').
  - Each tag state advances only when tx_ready=1. req_ready stays 0 during tags.
  - Tag bytes count neither toward MAX_BURST nor toward the idle timer.
- Not defined: TAG0/TAG1 are absent; IDLE goes directly to STREAM with identical timing otherwise.

Test Plan:
- Reset then idle: reset high 3 cycles, all req_valid=0 → tx_valid=0, req_ready=0, busy=0, grant_id=0 for 20 cycles.
- Line lock: req0 sends "AB\n" while req1 is valid with "X" from cycle 0; tx_ready always 1 → ser sequence 41,42,0A,58. Requester 1 is granted only after 0x0A, with one bubble cycle.
- Round-robin: all 4 requesters continuously valid with "\n" bytes → grant_id sequence 0,1,2,3,0,1.
- Burst limit: MAX_BURST=4; req2 streams 10 bytes 0x61.. with no newline; req3 valid → after 4 bytes (61..64) grant passes to req3; req2 resumes at 0x65 on its next grant.
- Idle timeout plus backpressure: req1 sends 1 byte then drops valid; tx_ready toggles 1/0 every cycle → release exactly IDLE_TIMEOUT cycles after the last transfer. No byte is transferred while tx_ready=0.
- Tag feature (SER_TX_ARB_TAG_EN defined): req2 sends "hi\n" → tx bytes 32,3A,68,69,0A. With the macro undefined → 68,69,0A.
